game_cmd_scheduler: RTL and testbench



---
 rtl/tetris_cmd_pkg.sv | 55 +++++
 rtl/gravity_timer.sv | 46 ++++
 rtl/game_cmd_scheduler.sv | 167 ++++++++++++++++
 tb/tb_game_cmd_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_cmd_pkg.sv
// Shared encodings for the game command scheduler: command codes, FSM states,
// pending-request bit layout and the fixed arbitration priority.
package tetris_cmd_pkg;

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_LEFT      = 3'd1;
  localparam logic [2:0] CMD_RIGHT     = 3'd2;
  localparam logic [2:0] CMD_ROTATE    = 3'd3;
  localparam logic [2:0] CMD_SOFT_DROP = 3'd4;
  localparam logic [2:0] CMD_GRAVITY   = 3'd5;

  typedef enum logic [1:0] {
    ST_WAIT_START = 2'd0,
    ST_RUN        = 2'd1,
    ST_OVER       = 2'd2
  } sched_state_e;

  // Pending bits 0..3 line up with the key vector {down, up, right, left}.
  localparam int PB_LEFT    = 0;
  localparam int PB_RIGHT   = 1;
  localparam int PB_ROTATE  = 2;
  localparam int PB_DROP    = 3;
  localparam int PB_GRAVITY = 4;
  localparam int NUM_PEND   = 5;

  typedef logic [NUM_PEND-1:0] pend_t;

  // Keys that may auto-repeat: LEFT, RIGHT, SOFT_DROP (never ROTATE).
  localparam logic [3:0] REPEAT_KEYS = 4'b1011;

  // Priority: GRAVITY > ROTATE > LEFT > RIGHT > SOFT_DROP.
  function automatic logic [2:0] pick_cmd(input pend_t p);
    if (p[PB_GRAVITY])     return CMD_GRAVITY;
    else if (p[PB_ROTATE]) return CMD_ROTATE;
    else if (p[PB_LEFT])   return CMD_LEFT;
    else if (p[PB_RIGHT])  return CMD_RIGHT;
    else if (p[PB_DROP])   return CMD_SOFT_DROP;
    else                   return CMD_NONE;
  endfunction

  function automatic pend_t cmd_mask(input logic [2:0] code);
    pend_t m;
    m = '0;
    case (code)
      CMD_LEFT:      m[PB_LEFT]    = 1'b1;
      CMD_RIGHT:     m[PB_RIGHT]   = 1'b1;
      CMD_ROTATE:    m[PB_ROTATE]  = 1'b1;
      CMD_SOFT_DROP: m[PB_DROP]    = 1'b1;
      CMD_GRAVITY:   m[PB_GRAVITY] = 1'b1;
      default:       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// Level-dependent gravity down-counter; emits a one-cycle tick when it
// reaches zero and reloads with the period computed at that moment.
module gravity_timer #(
  parameter logic [31:0] TICK_BASE = 32'd50000000,
  parameter logic [31:0] TICK_STEP = 32'd2500000,
  parameter logic [31:0] TICK_MIN  = 32'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] level,
  output logic       tick
);

  logic [31:0] product;
  logic [31:0] period;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    product = {28'd0, level} * TICK_STEP;
    // The first term guards the subtraction below against wrap-around.
    if ((product > TICK_BASE) || ((TICK_BASE - product) < TICK_MIN)) begin
      period = TICK_MIN;
    end else begin
      period = TICK_BASE - product;
    end

    tick  = enable && (cnt_q == '0);
    cnt_d = cnt_q;
    if (load || tick) begin
      cnt_d = period - 32'd1;
    end else if (enable) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_cmd_scheduler.sv
// Merges key edges and gravity ticks into one prioritised command stream.
// Optional KEY_AUTOREPEAT_EN adds hold-to-repeat for LEFT/RIGHT/SOFT_DROP.
module game_cmd_scheduler
  import tetris_cmd_pkg::*;
#(
  parameter logic [31:0] TICK_BASE    = 32'd50000000,
  parameter logic [31:0] TICK_STEP    = 32'd2500000,
  parameter logic [31:0] TICK_MIN     = 32'd5000000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter logic [31:0] REPEAT_DELAY = 32'd25000000,
  parameter logic [31:0] REPEAT_RATE  = 32'd5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [6:0] score,
  input  logic       fail,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic [1:0] state,
  output logic [7:0] drop_cnt
);

  sched_state_e state_q, state_d;
  logic [3:0]   key_vec, key_prev_q, key_edge, rep_req;
  pend_t        pend_q, pend_d, req, load_mask, drops;
  logic         valid_q, valid_d;
  logic [2:0]   code_q, code_d, win_code;
  logic [7:0]   drop_q, drop_d;
  logic [8:0]   drop_sum;
  logic         grav_en, grav_load, grav_tick;
  logic         unused_score_lsbs;

  assign key_vec           = {key_down, key_up, key_right, key_left};
  assign key_edge          = key_vec & ~key_prev_q;
  assign unused_score_lsbs = ^score[2:0];

  gravity_timer #(
    .TICK_BASE (TICK_BASE),
    .TICK_STEP (TICK_STEP),
    .TICK_MIN  (TICK_MIN)
  ) u_gravity (
    .clk    (clk),
    .rst    (rst),
    .enable (grav_en),
    .load   (grav_load),
    .level  (score[6:3]),
    .tick   (grav_tick)
  );

`ifdef KEY_AUTOREPEAT_EN
  logic [31:0] rep_q, rep_d;

  // One shared counter: any key change restarts the delay phase.
  always_comb begin
    rep_req = '0;
    if (key_vec != key_prev_q) begin
      rep_d = REPEAT_DELAY - 32'd1;
    end else if (rep_q == '0) begin
      rep_d   = REPEAT_RATE - 32'd1;
      rep_req = key_vec & key_prev_q & REPEAT_KEYS;
    end else begin
      rep_d = rep_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_req = '0;
`endif

  // Handshake: a command transfers in any cycle with cmd_valid & cmd_ready;
  // while valid is high and ready low, cmd_code is held unchanged.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    valid_d   = valid_q;
    code_d    = code_q;
    drop_d    = drop_q;
    grav_en   = 1'b0;
    grav_load = 1'b0;
    req       = '0;
    load_mask = '0;
    drops     = '0;
    drop_sum  = {1'b0, drop_q};
    win_code  = pick_cmd(pend_q);

    case (state_q)
      ST_WAIT_START: begin
        if (|key_edge) begin
          state_d   = ST_RUN;
          grav_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (fail) begin
          state_d = ST_OVER;
          pend_d  = '0;
          valid_d = 1'b0;
          code_d  = CMD_NONE;
        end else begin
          grav_en = 1'b1;
          req     = {grav_tick, key_edge | rep_req};
          if (!valid_q || cmd_ready) begin
            valid_d   = |pend_q;
            code_d    = win_code;
            load_mask = cmd_mask(win_code);
          end
          // A request landing on its own bit as it loads re-pends, not a drop.
          drops  = req & pend_q & ~load_mask;
          pend_d = (pend_q & ~load_mask) | req;
          for (int i = 0; i < NUM_PEND; i++) begin
            drop_sum = drop_sum + {8'd0, drops[i]};
          end
          drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
      end
      ST_OVER: begin
        pend_d  = '0;
        valid_d = 1'b0;
        code_d  = CMD_NONE;
      end
      default: begin
        state_d = ST_WAIT_START;
        pend_d  = '0;
        valid_d = 1'b0;
        code_d  = CMD_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_START;
      pend_q     <= '0;
      key_prev_q <= '0;
      valid_q    <= 1'b0;
      code_q     <= CMD_NONE;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      key_prev_q <= key_vec;
      valid_q    <= valid_d;
      code_q     <= code_d;
      drop_q     <= drop_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;
  assign state     = state_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_game_cmd_scheduler.sv
// Directed bench for game_cmd_scheduler: stimulus pushes expected
// {cycle, code} entries; a negedge monitor pops them on each handshake.
`timescale 1ns/1ps
module tb_game_cmd_scheduler;
  import tetris_cmd_pkg::*;

  localparam int W = 35;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic [6:0] score = '0;
  logic       fail = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [1:0] state;
  logic [7:0] drop_cnt;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       mon_en = 1'b0;
  logic       hold_seen = 1'b0;
  logic [2:0] hold_code = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_cmd_scheduler #(
    .TICK_BASE    (32'd100),
    .TICK_STEP    (32'd10),
    .TICK_MIN     (32'd20)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY (32'd30),
    .REPEAT_RATE  (32'd10)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_left  (key_left),
    .key_right (key_right),
    .key_up    (key_up),
    .key_down  (key_down),
    .score     (score),
    .fail      (fail),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .state     (state),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_cmd(input logic [2:0] code, input int at);
    exp_q.push_back({32'(at), code});
  endtask

  task automatic pulse_key(input int idx);
    case (idx)
      0: key_left  = 1'b1;
      1: key_right = 1'b1;
      2: key_up    = 1'b1;
      default: key_down = 1'b1;
    endcase
    step();
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
  endtask

  task automatic enter_run(output int a);
    step();
    a = cyc;
    pulse_key(2);
    @(negedge clk);
    chk("run_entry_state", 32'(state), 32'(ST_RUN));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    fail = 1'b0; score = '0; cmd_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(ST_WAIT_START));
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_code", 32'(cmd_code), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // Drops seen by cycle a+rel in the held-LEFT scenario.
  function automatic int exp_drops(input int rel);
    int d;
    d = 0;
    if (rel >= 201) d++;
    if (rel >= 301) d++;
`ifdef KEY_AUTOREPEAT_EN
    if (rel >= 36) d += (rel - 36) / 10;
`endif
    return d;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: got code %0d at cycle %0d, expected no command", cmd_code, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd_code", 32'(cmd_code), 32'(mon_e[2:0]));
          chk("cmd_cycle", 32'(cyc), mon_e[34:3]);
        end
      end
      if (!cmd_valid) chk("idle_code", 32'(cmd_code), 32'd0);
      if (hold_seen && cmd_valid) chk("hold_stable", 32'(cmd_code), 32'(hold_code));
      hold_seen = cmd_valid && !cmd_ready;
      hold_code = cmd_code;
    end else begin
      hold_seen = 1'b0;
    end
  end

  initial begin
    int a;
    int c;
    int r;

    // Entry, latency and level-dependent gravity period.
    do_reset();
    enter_run(a);
    expect_cmd(CMD_LEFT, a + 7);
    expect_cmd(CMD_GRAVITY, a + 102);
    expect_cmd(CMD_GRAVITY, a + 202);
    expect_cmd(CMD_GRAVITY, a + 252);
    expect_cmd(CMD_GRAVITY, a + 302);
    expect_cmd(CMD_GRAVITY, a + 352);
    expect_cmd(CMD_GRAVITY, a + 372);
    expect_cmd(CMD_GRAVITY, a + 392);
    wait_until(a + 5);
    pulse_key(0);
    wait_until(a + 150);
    score = 7'd40;
    wait_until(a + 320);
    score = 7'd127;
    wait_until(a + 400);
    chk("s1_drained", 32'(exp_q.size()), 32'd0);
    chk("s1_drop", 32'(drop_cnt), 32'd0);

    // fail ignored before start; simultaneous edges; edge coinciding with load.
    do_reset();
    step();
    fail = 1'b1;
    step();
    fail = 1'b0;
    @(negedge clk);
    chk("fail_in_wait", 32'(state), 32'(ST_WAIT_START));
    enter_run(a);
    wait_until(a + 10);
    c = cyc;
    expect_cmd(CMD_ROTATE, c + 2);
    expect_cmd(CMD_LEFT, c + 3);
    expect_cmd(CMD_LEFT, c + 4);
    key_up = 1'b1;
    key_left = 1'b1;
    step();
    key_up = 1'b0;
    key_left = 1'b0;
    step();
    pulse_key(0);
    wait_until(a + 40);
    chk("s2_drained", 32'(exp_q.size()), 32'd0);
    chk("s2_no_drop", 32'(drop_cnt), 32'd0);
    cmd_ready = 1'b0;
    pulse_key(1);
    wait_until(a + 50);
    @(negedge clk);
    chk("s2_held_valid", 32'(cmd_valid), 32'd1);
    chk("s2_held_code", 32'(cmd_code), 32'(CMD_RIGHT));

    // Held LEFT against a stalled consumer, coalesced gravity, then game over.
    do_reset();
    cmd_ready = 1'b0;
    enter_run(a);
    wait_until(a + 5);
    key_left = 1'b1;
    wait_until(a + 150);
    @(negedge clk);
    chk("s3_valid", 32'(cmd_valid), 32'd1);
    chk("s3_code", 32'(cmd_code), 32'(CMD_LEFT));
    wait_until(a + 199);
    @(negedge clk);
    chk("s3_drop_t1", 32'(drop_cnt), 32'(exp_drops(199)));
    wait_until(a + 201);
    @(negedge clk);
    chk("s3_drop_t2", 32'(drop_cnt), 32'(exp_drops(201)));
    wait_until(a + 301);
    @(negedge clk);
    chk("s3_drop_t3", 32'(drop_cnt), 32'(exp_drops(301)));
    wait_until(a + 310);
    fail = 1'b1;
    step();
    fail = 1'b0;
    key_left = 1'b0;
    @(negedge clk);
    chk("over_state", 32'(state), 32'(ST_OVER));
    chk("over_valid", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      repeat (19) step();
      pulse_key(i % 4);
    end
    @(negedge clk);
    chk("over_stays", 32'(state), 32'(ST_OVER));
    chk("over_drop", 32'(drop_cnt), 32'(exp_drops(310)));

`ifdef KEY_AUTOREPEAT_EN
    // RIGHT held for 60 cycles repeats after the delay, then at the rate.
    do_reset();
    enter_run(a);
    wait_until(a + 5);
    r = cyc;
    expect_cmd(CMD_RIGHT, r + 2);
    expect_cmd(CMD_RIGHT, r + 32);
    expect_cmd(CMD_RIGHT, r + 42);
    expect_cmd(CMD_RIGHT, r + 52);
    key_right = 1'b1;
    wait_until(r + 60);
    key_right = 1'b0;
    wait_until(r + 80);
    chk("rep_drained", 32'(exp_q.size()), 32'd0);
`else
    r = 0;
`endif

    do_reset();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
